breath_sequencer: RTL and testbench

Brightness-profile generator that drives the existing PWM stage of the breathing-LED design. It divides the system clock into step ticks and walks a 4-phase state machine: rise, hold at peak, fall, hold at zero. It emits a BITS-wide brightness word directly consumable by the PWM `brightness` input. It supersedes the separate prescaler plus up/down counter pair, adding peak/trough dwell, an enable, and an optional gamma curve.

---
 rtl/breath_sequencer_if.sv | 24 ++
 rtl/breath_sequencer.sv | 120 ++++++++++++
 tb/tb_breath_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/breath_sequencer_if.sv
// breath_sequencer_if: groups the enable input with the brightness/phase/step_tick outputs.
// The master modport is the sequencer; the slave modport is the PWM stage or any other consumer.
interface breath_sequencer_if #(
    parameter int unsigned BITS = 5
);
    logic            enable;
    logic [BITS-1:0] brightness;
    logic [1:0]      phase;
    logic            step_tick;

    modport master (
        input  enable,
        output brightness,
        output phase,
        output step_tick
    );

    modport slave (
        output enable,
        input  brightness,
        input  phase,
        input  step_tick
    );
endinterface

// File: rtl/breath_sequencer.sv
// breath_sequencer: brightness-profile generator for the breathing-LED PWM stage.
// The prescaler divides enabled clocks into step ticks. On each tick a 4-phase FSM
// (rise, hold high, fall, hold low) advances a saturating level. The level maps to
// the brightness word.
// Optional feature: define BREATH_GAMMA_EN for brightness = (level*(level+1)) >> BITS.
// Otherwise brightness = level.
module breath_sequencer #(
    parameter int unsigned BITS          = 5,
    parameter int unsigned PRESCALE_BITS = 18,
    parameter int unsigned HOLD_TICKS    = 0
) (
    input logic                 clk,
    input logic                 reset,
    breath_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        StRise     = 2'd0,
        StHoldHigh = 2'd1,
        StFall     = 2'd2,
        StHoldLow  = 2'd3
    } state_e;

    localparam logic [BITS-1:0] LevelMax = '1;
    localparam bit              HoldEn   = (HOLD_TICKS != 0);
    // Last dwell count before leaving a hold state; unused when HOLD_TICKS is 0.
    localparam logic [7:0]      HoldLast = HoldEn ? 8'(HOLD_TICKS - 1) : 8'd0;

    logic [PRESCALE_BITS-1:0] presc_q;
    logic [BITS-1:0]          level_q, level_d;
    state_e                   state_q, state_d;
    logic [7:0]               hold_q, hold_d;
    logic                     step_tick_q;
    logic                     tick;

    assign tick = bus.enable && (presc_q == '1);

    // Prescaler: advances only while enabled and wraps naturally at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else if (bus.enable) begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // Profile state registers and the registered tick pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StRise;
            level_q     <= '0;
            hold_q      <= '0;
            step_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            hold_q      <= hold_d;
            step_tick_q <= tick;
        end
    end

    // Next-state logic: nothing moves without a tick.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        hold_d  = hold_q;
        if (tick) begin
            unique case (state_q)
                StRise: begin
                    level_d = level_q + 1'b1;
                    if (level_d == LevelMax) begin
                        hold_d  = '0;
                        state_d = HoldEn ? StHoldHigh : StFall;
                    end
                end
                StHoldHigh: begin
                    if (hold_q == HoldLast) begin
                        state_d = StFall;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
                StFall: begin
                    level_d = level_q - 1'b1;
                    if (level_d == '0) begin
                        hold_d  = '0;
                        state_d = HoldEn ? StHoldLow : StRise;
                    end
                end
                StHoldLow: begin
                    if (hold_q == HoldLast) begin
                        state_d = StRise;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
                default: state_d = StRise;
            endcase
        end
    end

`ifdef BREATH_GAMMA_EN
    logic [2*BITS:0] gamma_prod;

    // Gamma curve: the +1 keeps f(MAX) == MAX without a lookup table.
    always_comb begin
        gamma_prod     = (2*BITS+1)'(level_q) * ((2*BITS+1)'(level_q) + 1'b1);
        bus.brightness = gamma_prod[2*BITS-1:BITS];
    end
`else
    // Linear mapping.
    always_comb begin
        bus.brightness = level_q;
    end
`endif

    assign bus.phase     = state_q;
    assign bus.step_tick = step_tick_q;

endmodule

// File: tb/tb_breath_sequencer.sv
// tb_breath_sequencer: random enable/reset stimulus applied to two sequencers,
// one with no dwell and one with a 3-tick dwell. Each is checked against a model
// that derives level and phase from the number of ticks since reset.
module tb_breath_sequencer;

    localparam int unsigned BITS = 5;
    localparam int unsigned PB   = 2;
    localparam int          MAXL = (1 << BITS) - 1;
    localparam int          PRE  = 1 << PB;

    logic clk = 1'b0;
    logic reset;
    logic en;

    breath_sequencer_if #(.BITS(BITS)) bus0 ();
    breath_sequencer_if #(.BITS(BITS)) bus1 ();

    assign bus0.enable = en;
    assign bus1.enable = en;

    breath_sequencer #(.BITS(BITS), .PRESCALE_BITS(PB), .HOLD_TICKS(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.master)
    );

    breath_sequencer #(.BITS(BITS), .PRESCALE_BITS(PB), .HOLD_TICKS(3)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: enabled edges and ticks since reset, and the last edge's tick flag.
    int edge_cnt;
    int ticks;
    int tick_exp;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected level and phase after n ticks, from the profile shape alone.
    task automatic profile(input int n, input int h, output int lvl, output int ph);
        int t;
        int p;
        t = 2 * MAXL + 2 * h;
        p = n % t;
        if (p < MAXL) begin
            lvl = p;         ph = 0;
        end else if (p == MAXL) begin
            lvl = MAXL;      ph = (h > 0) ? 1 : 2;
        end else if (p < MAXL + h) begin
            lvl = MAXL;      ph = 1;
        end else if (p <= 2 * MAXL + h - 1) begin
            lvl = MAXL - (p - MAXL - h); ph = 2;
        end else if (p == 2 * MAXL + h) begin
            lvl = 0;         ph = 3;
        end else begin
            lvl = 0;         ph = 3;
        end
    endtask

    function automatic int bright_of(input int lvl);
`ifdef BREATH_GAMMA_EN
        return (lvl * (lvl + 1)) >> BITS;
`else
        return lvl;
`endif
    endfunction

    task automatic model_reset();
        edge_cnt = 0;
        ticks    = 0;
        tick_exp = 0;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else if (en) begin
            edge_cnt++;
            tick_exp = ((edge_cnt % PRE) == 0) ? 1 : 0;
            if (tick_exp != 0) ticks++;
        end else begin
            tick_exp = 0;
        end
    endtask

    task automatic check_all(input string tag);
        int l0, p0, l1, p1;
        profile(ticks, 0, l0, p0);
        profile(ticks, 3, l1, p1);
        check({tag, " h0 brightness"}, int'(bus0.brightness), bright_of(l0));
        check({tag, " h0 phase"},      int'(bus0.phase),      p0);
        check({tag, " h0 step_tick"},  int'(bus0.step_tick),  tick_exp);
        check({tag, " h3 brightness"}, int'(bus1.brightness), bright_of(l1));
        check({tag, " h3 phase"},      int'(bus1.phase),      p1);
        check({tag, " h3 step_tick"},  int'(bus1.step_tick),  tick_exp);
    endtask

    task automatic check_reset_now(input string tag);
        check({tag, " h0 brightness"}, int'(bus0.brightness), 0);
        check({tag, " h0 phase"},      int'(bus0.phase),      0);
        check({tag, " h0 step_tick"},  int'(bus0.step_tick),  0);
        check({tag, " h3 brightness"}, int'(bus1.brightness), 0);
        check({tag, " h3 phase"},      int'(bus1.phase),      0);
        check({tag, " h3 step_tick"},  int'(bus1.step_tick),  0);
    endtask

    initial begin
        int  freeze_left;
        bit  froze;
        bit  fall_rst_done;
        int  l0, p0;

        freeze_left   = 0;
        froze         = 1'b0;
        fall_rst_done = 1'b0;
        reset = 1'b1;
        en    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("reset");
        reset = 1'b0;
        en    = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            model_edge();
            @(negedge clk);
            check_all($sformatf("cyc%0d", cyc));

            // Enable stimulus: one directed 50-clock freeze at level 10, else random.
            // The first 400 cycles keep enable high to match the plain schedule.
            profile(ticks, 0, l0, p0);
            if (freeze_left > 0) begin
                en = 1'b0;
                freeze_left--;
            end else if (!froze && !reset && l0 == 10 && p0 == 0) begin
                froze       = 1'b1;
                en          = 1'b0;
                freeze_left = 49;
            end else if (cyc < 400) begin
                en = 1'b1;
            end else begin
                en = ($urandom_range(0, 9) != 0);
            end

            // Reset stimulus: asserted between edges, so outputs must clear at once.
            if (reset) begin
                reset = 1'b0;
            end else if ((!fall_rst_done && l0 == 20 && p0 == 2) ||
                         (cyc > 1500 && $urandom_range(0, 699) == 0)) begin
                fall_rst_done = fall_rst_done | (l0 == 20 && p0 == 2);
                reset = 1'b1;
                #1;
                check_reset_now($sformatf("async_rst%0d", cyc));
                model_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
